// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter for the shared single-port data RAM.
// Supports locked bursts with a starvation bound and returns ack/read data one cycle after the grant.
module ram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic              m0_lock_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               last_gnt;
    logic [CNT_W-1:0]   hold_cnt, hold_nxt, cnt_inc;
    logic [1:0]         ack_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               win_lock, other_req, same_owner;

    // Handshake: a master raises req and holds its fields stable until gnt is seen
    // high in the same cycle; that cycle is the access, and ack follows one cycle later.
    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (!rst) begin
            if (state == OWN0 && m0_req_i) begin
                m0_gnt_o = 1'b1;
            end else if (state == OWN1 && m1_req_i) begin
                m1_gnt_o = 1'b1;
            end else if (m0_req_i && m1_req_i) begin
                m0_gnt_o = last_gnt;
                m1_gnt_o = !last_gnt;
            end else begin
                m0_gnt_o = m0_req_i;
                m1_gnt_o = m1_req_i;
            end
        end
    end

    always_comb begin
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        win_lock   = 1'b0;
        other_req  = 1'b0;
        same_owner = 1'b0;
        cnt_inc    = '0;
        state_nxt  = IDLE;
        hold_nxt   = '0;
        if (m0_gnt_o) begin
            ram_we_o   = m0_we_i;
            ram_addr_o = m0_addr_i;
            ram_data_o = m0_data_i;
            win_lock   = m0_lock_i;
            other_req  = m1_req_i;
            same_owner = (state == OWN0);
        end else if (m1_gnt_o) begin
            ram_we_o   = m1_we_i;
            ram_addr_o = m1_addr_i;
            ram_data_o = m1_data_i;
            win_lock   = m1_lock_i;
            other_req  = m0_req_i;
            same_owner = (state == OWN1);
        end
        // Count only contended locked beats; a new owner starts again from one.
        if (other_req) begin
            cnt_inc = (same_owner ? hold_cnt : '0) + CNT_W'(1);
        end
        if ((m0_gnt_o || m1_gnt_o) && win_lock) begin
            if (other_req && cnt_inc == CNT_W'(MAX_HOLD)) begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end else begin
                state_nxt = m0_gnt_o ? OWN0 : OWN1;
                hold_nxt  = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            hold_cnt <= '0;
            ack_q    <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            ack_q    <= {m1_gnt_o, m0_gnt_o};
            if (m0_gnt_o || m1_gnt_o) begin
                last_gnt <= m1_gnt_o;
                rdata_q  <= ram_we_o ? '0 : ram_data_i;
            end
        end
    end

    assign m0_ack_o  = ack_q[0];
    assign m1_ack_o  = ack_q[1];
    assign m0_data_o = rdata_q;
    assign m1_data_o = rdata_q;
    assign dbg_state = state;

endmodule
